// File: rtl/nios2_c_sysid_pkg.sv
// rtl/nios2_c_sysid_pkg.sv - shared types and constants for the system-ID checker
package nios2_c_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_FIN
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Also consumed by the software header generator; keep in step with the sysid IP.
  localparam logic [31:0] SYSID_EXPECTED_ID = 32'h00012345;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'h535422F6;

  localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/nios2_c_sysid_checker_if.sv
// rtl/nios2_c_sysid_checker_if.sv - Avalon-MM read port between checker and sysid slave
interface nios2_c_sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata
  );
endinterface

// File: rtl/nios2_c_avmm_read_timer.sv
// rtl/nios2_c_avmm_read_timer.sv - stall/latency cycle counter with clear and expire
module nios2_c_avmm_read_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;

  // Expire fires on the counting cycle that would bring the count to limit.
  assign expire = inc && (({1'b0, cnt} + {{W{1'b0}}, 1'b1}) == {1'b0, limit});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/nios2_c_sysid_checker.sv
// rtl/nios2_c_sysid_checker.sv - reads sysid words 0/1 and compares against expected values
module nios2_c_sysid_checker
  import nios2_c_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  nios2_c_sysid_checker_if.master        bus,
  output logic                           busy,
  output logic                           done,
  output logic                           id_ok,
  output logic                           ts_ok,
  output logic                           timeout,
  output logic [31:0]                    id_word,
  output logic [31:0]                    ts_word
);
  localparam logic                   ZERO_LAT  = (READ_LATENCY == 0);
  localparam logic [SYSID_CNT_W-1:0] LAT_LIMIT = SYSID_CNT_W'(READ_LATENCY);
  localparam logic [SYSID_CNT_W-1:0] TO_LIMIT  = SYSID_CNT_W'(TIMEOUT_CYCLES);

  sysid_state_e state;
  logic         auto_pend;
  logic         rd_q;
  logic         addr_q;

  logic                   rd_state;
  logic                   lat_state;
  logic                   is_id;
  logic                   capture;
  logic                   tmr_inc;
  logic                   tmr_clr;
  logic                   tmr_exp;
  logic [SYSID_CNT_W-1:0] tmr_limit;

  assign bus.m_read    = rd_q;
  assign bus.m_address = addr_q;

  assign rd_state  = (state == S_RD_ID) || (state == S_RD_TS);
  assign lat_state = (state == S_LAT_ID) || (state == S_LAT_TS);
  assign is_id     = (state == S_RD_ID) || (state == S_LAT_ID);
  // One counter serves both jobs: stall cycles in RD_x, latency cycles in LAT_x.
  assign tmr_inc   = (rd_state && bus.m_waitrequest) || lat_state;
  assign tmr_clr   = !tmr_inc || tmr_exp;
  assign tmr_limit = lat_state ? LAT_LIMIT : TO_LIMIT;
  assign capture   = (rd_state && !bus.m_waitrequest && ZERO_LAT) || (lat_state && tmr_exp);

  nios2_c_avmm_read_timer #(.W(SYSID_CNT_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .inc     (tmr_inc),
    .limit   (tmr_limit),
    .expire  (tmr_exp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      auto_pend <= (AUTO_START != 0);
      rd_q      <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_word   <= '0;
      ts_word   <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        if (is_id) begin
          id_word <= bus.m_readdata;
          id_ok   <= (bus.m_readdata == EXPECTED_ID);
          rd_q    <= 1'b1;
          addr_q  <= SYSID_ADDR_TS;
          state   <= S_RD_TS;
        end else begin
          ts_word <= bus.m_readdata;
          ts_ok   <= (bus.m_readdata == EXPECTED_TS);
          rd_q    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_FIN;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start || auto_pend) begin
              auto_pend <= 1'b0;
              id_ok     <= 1'b0;
              ts_ok     <= 1'b0;
              timeout   <= 1'b0;
              busy      <= 1'b1;
              rd_q      <= 1'b1;
              addr_q    <= SYSID_ADDR_ID;
              state     <= S_RD_ID;
            end
          end
          S_RD_ID, S_RD_TS: begin
            if (!bus.m_waitrequest) begin
              rd_q  <= 1'b0;
              state <= is_id ? S_LAT_ID : S_LAT_TS;
            end else if (tmr_exp) begin
              timeout <= 1'b1;
              rd_q    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_FIN;
            end
          end
          S_FIN:   state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nios2_c_sysid_checker.sv
// tb/tb_nios2_c_sysid_checker.sv - directed self-checking bench for the sysid checker
module tb_nios2_c_sysid_checker;
  import nios2_c_sysid_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        wait0 = 1'b0;
  logic [31:0] id_val0 = 32'h00012345;
  logic [31:0] ts_val0 = 32'h535422F6;
  logic [31:0] rd1_data = 32'h0;

  logic        busy0, done0, id_ok0, ts_ok0, timeout0;
  logic [31:0] id_word0, ts_word0;
  logic        busy1, done1, id_ok1, ts_ok1, timeout1;
  logic [31:0] id_word1, ts_word1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  nios2_c_sysid_checker_if bus0 ();
  nios2_c_sysid_checker_if bus1 ();

  assign bus0.m_waitrequest = wait0;
  assign bus0.m_readdata    = bus0.m_address ? ts_val0 : id_val0;
  assign bus1.m_waitrequest = 1'b0;
  assign bus1.m_readdata    = rd1_data;

  nios2_c_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .bus(bus0.master),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0), .timeout(timeout0),
    .id_word(id_word0), .ts_word(ts_word0)
  );

  nios2_c_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bus(bus1.master),
    .busy(busy1), .done(done1), .id_ok(id_ok1), .ts_ok(ts_ok1), .timeout(timeout1),
    .id_word(id_word1), .ts_word(ts_word1)
  );

  task automatic test_reset();
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else pass_cnt++;
    total_cnt++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else pass_cnt++;
    total_cnt++; if (bus0.m_read !== 1'b0) $display("FAIL reset_m_read got %b want 0", bus0.m_read); else pass_cnt++;
    total_cnt++; if ({id_ok0, ts_ok0, timeout0} !== 3'b000) $display("FAIL reset_flags got %b want 000", {id_ok0, ts_ok0, timeout0}); else pass_cnt++;
    total_cnt++; if ({id_word0, ts_word0} !== 64'h0) $display("FAIL reset_words got %h want 0", {id_word0, ts_word0}); else pass_cnt++;
  endtask

  task automatic test_auto_start();
    int done_cyc = 0;
    int read_cyc = 0;
    int ts_cyc = 0;
    int busy1_seen = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus0.m_read && bus0.m_address == SYSID_ADDR_ID && read_cyc == 0) read_cyc = c;
      if (bus0.m_read && bus0.m_address == SYSID_ADDR_TS && ts_cyc == 0) ts_cyc = c;
      if (done0 && done_cyc == 0) done_cyc = c;
      if (busy1) busy1_seen = 1;
    end
    total_cnt++; if (read_cyc != 1) $display("FAIL auto_id_read_cycle got %0d want 1", read_cyc); else pass_cnt++;
    total_cnt++; if (ts_cyc != 2) $display("FAIL auto_ts_read_cycle got %0d want 2", ts_cyc); else pass_cnt++;
    total_cnt++; if (done_cyc != 3) $display("FAIL auto_done_cycle got %0d want 3", done_cyc); else pass_cnt++;
    total_cnt++; if ({id_ok0, ts_ok0, timeout0} !== 3'b110) $display("FAIL auto_flags got %b want 110", {id_ok0, ts_ok0, timeout0}); else pass_cnt++;
    total_cnt++; if (id_word0 !== 32'h00012345) $display("FAIL auto_id_word got %h want 00012345", id_word0); else pass_cnt++;
    total_cnt++; if (ts_word0 !== 32'h535422F6) $display("FAIL auto_ts_word got %h want 535422f6", ts_word0); else pass_cnt++;
    total_cnt++; if (busy1_seen != 0) $display("FAIL no_auto_start_busy got %0d want 0", busy1_seen); else pass_cnt++;
  endtask

  task automatic test_bad_id();
    int done_cyc = 0;
    int dones = 0;
    id_val0 = 32'h00012346;
    @(posedge clock); #1 start0 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clock); #1 start0 = 1'b0;
      @(negedge clock);
      if (done0) begin dones++; if (done_cyc == 0) done_cyc = c; end
    end
    total_cnt++; if (dones != 1) $display("FAIL bad_id_done_pulses got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (done_cyc != 3) $display("FAIL bad_id_done_cycle got %0d want 3", done_cyc); else pass_cnt++;
    total_cnt++; if ({id_ok0, ts_ok0, timeout0} !== 3'b010) $display("FAIL bad_id_flags got %b want 010", {id_ok0, ts_ok0, timeout0}); else pass_cnt++;
    total_cnt++; if (id_word0 !== 32'h00012346) $display("FAIL bad_id_word got %h want 00012346", id_word0); else pass_cnt++;
    id_val0 = 32'h00012345;
  endtask

  task automatic test_wait_states();
    int done_cyc = 0;
    int rd_cycles = 0;
    wait0 = 1'b1;
    @(posedge clock); #1 start0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1 start0 = 1'b0;
      if (rd_cycles == 10) wait0 = 1'b0;
      @(negedge clock);
      if (bus0.m_read && bus0.m_address == SYSID_ADDR_ID) rd_cycles++;
      if (done0 && done_cyc == 0) done_cyc = c;
    end
    // 10 stalled ID cycles + accept, one TS cycle, then FIN.
    total_cnt++; if (rd_cycles != 11) $display("FAIL wait_id_read_cycles got %0d want 11", rd_cycles); else pass_cnt++;
    total_cnt++; if (done_cyc != 13) $display("FAIL wait_done_cycle got %0d want 13", done_cyc); else pass_cnt++;
    total_cnt++; if ({id_ok0, ts_ok0, timeout0} !== 3'b110) $display("FAIL wait_flags got %b want 110", {id_ok0, ts_ok0, timeout0}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int done_cyc = 0;
    int dones = 0;
    int stalls = 0;
    wait0 = 1'b1;
    @(posedge clock); #1 start0 = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clock); #1 start0 = 1'b0;
      @(negedge clock);
      if (bus0.m_read && wait0) stalls++;
      if (done0) begin dones++; if (done_cyc == 0) done_cyc = c; end
    end
    wait0 = 1'b0;
    total_cnt++; if (stalls != 255) $display("FAIL timeout_stall_cycles got %0d want 255", stalls); else pass_cnt++;
    total_cnt++; if (done_cyc != 256) $display("FAIL timeout_done_cycle got %0d want 256", done_cyc); else pass_cnt++;
    total_cnt++; if (dones != 1) $display("FAIL timeout_done_pulses got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if ({id_ok0, ts_ok0, timeout0} !== 3'b001) $display("FAIL timeout_flags got %b want 001", {id_ok0, ts_ok0, timeout0}); else pass_cnt++;
    total_cnt++; if (id_word0 !== 32'h00012345) $display("FAIL timeout_id_word_kept got %h want 00012345", id_word0); else pass_cnt++;
  endtask

  task automatic test_read_latency();
    int done_cyc = 0;
    logic acc = 1'b0, acc_a = 1'b0;
    logic d1 = 1'b0, d1_a = 1'b0, d2 = 1'b0, d2_a = 1'b0;
    @(posedge clock); #1 start1 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1 start1 = 1'b0;
      d2 = d1; d2_a = d1_a; d1 = acc; d1_a = acc_a;
      if (d2) rd1_data = d2_a ? 32'h535422F6 : 32'h00012345;
      else    rd1_data = 32'hBAD00000 | 32'(c);
      @(negedge clock);
      acc = bus1.m_read; acc_a = bus1.m_address;
      if (done1 && done_cyc == 0) done_cyc = c;
    end
    total_cnt++; if (done_cyc != 7) $display("FAIL lat2_done_cycle got %0d want 7", done_cyc); else pass_cnt++;
    total_cnt++; if (id_word1 !== 32'h00012345) $display("FAIL lat2_id_word got %h want 00012345", id_word1); else pass_cnt++;
    total_cnt++; if (ts_word1 !== 32'h535422F6) $display("FAIL lat2_ts_word got %h want 535422f6", ts_word1); else pass_cnt++;
    total_cnt++; if ({id_ok1, ts_ok1, timeout1} !== 3'b110) $display("FAIL lat2_flags got %b want 110", {id_ok1, ts_ok1, timeout1}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int done_cyc = 0;
    int dones = 0;
    wait0 = 1'b0;
    @(posedge clock); #1 start0 = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clock); #1 start0 = 1'b0;
      @(negedge clock);
    end
    total_cnt++; if ({bus0.m_read, bus0.m_address} !== 2'b11) $display("FAIL mid_in_rd_ts got %b want 11", {bus0.m_read, bus0.m_address}); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (bus0.m_read !== 1'b0) $display("FAIL mid_m_read_drop got %b want 0", bus0.m_read); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL mid_busy got %b want 0", busy0); else pass_cnt++;
    total_cnt++; if ({id_ok0, id_word0} !== 33'h0) $display("FAIL mid_id_cleared got %h want 0", {id_ok0, id_word0}); else pass_cnt++;
    @(posedge clock); #1 reset_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clock); #1 start0 = (c == 2);
      @(negedge clock);
      if (done0) begin dones++; if (done_cyc == 0) done_cyc = c; end
    end
    total_cnt++; if (dones != 1) $display("FAIL busy_start_ignored_pulses got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (done_cyc != 3) $display("FAIL rerun_done_cycle got %0d want 3", done_cyc); else pass_cnt++;
    total_cnt++; if ({busy0, id_ok0, ts_ok0} !== 3'b011) $display("FAIL rerun_state got %b want 011", {busy0, id_ok0, ts_ok0}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_bad_id();
    test_wait_states();
    test_timeout();
    test_read_latency();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
